// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with coordinate outputs, line/frame pulses and a delay line on sync/blank/active.
// Optional frame counter: define VGA_TIMING_FRAME_COUNT_EN to build it; otherwise o_frame_count is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int COORD_W    = 16,
  parameter int PIPE_DELAY = 0
) (
  input  logic               i_pix_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  output logic [COORD_W-1:0] o_horz_coord,
  output logic [COORD_W-1:0] o_vert_coord,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_horz_sync,
  output logic               o_vert_sync,
  output logic               o_horz_blank,
  output logic               o_vert_blank,
  output logic               o_in_active_area,
  output logic [15:0]        o_frame_count
);

  localparam longint H_TOTAL = longint'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam longint V_TOTAL = longint'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam longint COORD_RANGE = longint'(1) << COORD_W;

  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE ||
      PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end

  localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_END   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG  = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_END  = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_BEG  = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_END  = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic HS_IDLE = (H_SYNC_POL == 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (V_SYNC_POL == 0) ? 1'b1 : 1'b0;

  // Delay-line word layout: {hsync, vsync, hblank, vblank, active}
  localparam logic [4:0] PIPE_IDLE = {HS_IDLE, VS_IDLE, 1'b1, 1'b1, 1'b0};

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_zero_q;
  logic               v_zero_q;
  logic               h_wrap;
  logic               v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // h_zero_q/v_zero_q track "counter == 0" alongside the counters themselves.
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_zero_q <= 1'b1;
      v_zero_q <= 1'b1;
    end else if (i_enable) begin
      if (h_wrap) begin
        h_cnt    <= '0;
        h_zero_q <= 1'b1;
        v_cnt    <= v_wrap ? '0 : v_cnt + 1'b1;
        v_zero_q <= v_wrap;
      end else begin
        h_cnt    <= h_cnt + 1'b1;
        h_zero_q <= 1'b0;
      end
    end
  end

  assign o_horz_coord = h_cnt;
  assign o_vert_coord = v_cnt;

  // Pulses are masked while disabled or in reset so a frozen counter at 0 never looks like a new line.
  assign o_line_start  = h_zero_q & i_enable & i_reset_n;
  assign o_frame_start = h_zero_q & v_zero_q & i_enable & i_reset_n;

  logic       h_act;
  logic       v_act;
  logic       h_in_sync;
  logic       v_in_sync;
  logic [4:0] dec;

  assign h_act     = (h_cnt < H_ACT_END);
  assign v_act     = (v_cnt < V_ACT_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign dec       = {h_in_sync ^ HS_IDLE, v_in_sync ^ VS_IDLE, ~h_act, ~v_act, h_act & v_act};

  // Stage 0 is the mandatory decode register; stages 1..PIPE_DELAY match pixel-source latency.
  logic [4:0] pipe_q [PIPE_DELAY+1];

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) pipe_q[i] <= PIPE_IDLE;
    end else if (i_enable) begin
      pipe_q[0] <= dec;
      for (int i = 1; i <= PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign o_horz_sync      = pipe_q[PIPE_DELAY][4];
  assign o_vert_sync      = pipe_q[PIPE_DELAY][3];
  assign o_horz_blank     = pipe_q[PIPE_DELAY][2];
  assign o_vert_blank     = pipe_q[PIPE_DELAY][1];
  assign o_in_active_area = pipe_q[PIPE_DELAY][0];

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  // Counts on the edge entering (0,0), so the first frame after reset reads 0.
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_cnt_q <= '0;
    end else if (i_enable && h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_frame_count = frame_cnt_q;
`else
  assign o_frame_count = '0;
`endif

endmodule
